// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and constants for the pong game sequencer.
package pong_pkg;

  // state     | meaning
  // IDLE      | waiting for start, ball parked at centre
  // SERVE     | ball held at centre while the serve delay runs
  // PLAY      | ball advances one pixel per frame tick
  // POINT     | single cycle: credit scorer, decide serve or game over
  // GAME_OVER | winner latched, waiting for start to begin a new game
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  // Direction bits: 1 moves toward larger coordinates.
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Frame/paddle inputs and ball/score outputs of the pong game sequencer.
interface pong_game_ctrl_if #(
  parameter int BIT_WIDTH   = 10,
  parameter int SCORE_WIDTH = 4
);
  import pong_pkg::*;

  logic                   frameTick;
  logic                   startBtn;
  logic                   hitLeftPaddle;
  logic                   hitRightPaddle;
  logic [BIT_WIDTH-1:0]   ballX;
  logic [BIT_WIDTH-1:0]   ballY;
  logic [SCORE_WIDTH-1:0] scoreLeft;
  logic [SCORE_WIDTH-1:0] scoreRight;
  game_state_t            gameState;
  logic                   winnerLeft;

  modport master (
    output frameTick, startBtn, hitLeftPaddle, hitRightPaddle,
    input  ballX, ballY, scoreLeft, scoreRight, gameState, winnerLeft
  );

  modport slave (
    input  frameTick, startBtn, hitLeftPaddle, hitRightPaddle,
    output ballX, ballY, scoreLeft, scoreRight, gameState, winnerLeft
  );

endinterface

// File: rtl/pong_game_ctrl_serve_timer.sv
// Serve delay: down-counter reloaded while clear is high, done on the
// SERVE_DELAY-th frame tick after clear drops.
module serve_timer #(
  parameter int SERVE_DELAY = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic done
);
  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0] LOAD = CW'(SERVE_DELAY);
  localparam logic [CW-1:0] LAST = CW'(1);

  logic [CW-1:0] cnt;

  // Reload while cleared, otherwise count frame ticks down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - LAST;
    end
  end

  assign done = !clear && tick && (cnt == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball motion, paddle/wall bounces, scoring and
// serve / point / game-over sequencing.
//
// state     | meaning
// IDLE      | waiting for startBtn, ball at centre
// SERVE     | ball at centre, serve timer counting frame ticks
// PLAY      | per frame tick: paddle dx, miss check, wall dy, move
// POINT     | one cycle: increment scorer, go to SERVE or GAME_OVER
// GAME_OVER | ball at centre, winner held until startBtn
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH   = 10,
  parameter int FIELD_W     = 640,
  parameter int FIELD_H     = 480,
  parameter int BALL_RADIUS = 4,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  pong_game_ctrl_if.slave bus
);
  localparam logic [BIT_WIDTH-1:0]   X_MAX = BIT_WIDTH'(FIELD_W - 1);
  localparam logic [BIT_WIDTH-1:0]   X_CTR = BIT_WIDTH'(FIELD_W / 2);
  localparam logic [BIT_WIDTH-1:0]   Y_CTR = BIT_WIDTH'(FIELD_H / 2);
  localparam logic [BIT_WIDTH-1:0]   Y_LO  = BIT_WIDTH'(BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0]   Y_HI  = BIT_WIDTH'(FIELD_H - 1 - BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0]   STEP  = BIT_WIDTH'(1);
  localparam logic [SCORE_WIDTH-1:0] S_WIN = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [SCORE_WIDTH-1:0] S_ONE = SCORE_WIDTH'(1);

  game_state_t            state, state_n;
  logic [BIT_WIDTH-1:0]   ball_x, ball_x_n, ball_y, ball_y_n;
  logic                   dx, dx_n, dy, dy_n;
  logic                   dir_x, dir_y;
  logic [SCORE_WIDTH-1:0] score_l, score_l_n, score_r, score_r_n;
  logic                   winner_l, winner_l_n;
  logic                   left_scored, left_scored_n;
  logic                   serve_done;

  // The timer is held in reload outside SERVE, so a tick arriving on the
  // entry cycle is not counted.
  serve_timer #(.SERVE_DELAY(SERVE_DELAY)) u_serve_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != SERVE),
    .tick  (bus.frameTick),
    .done  (serve_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Ball, direction, score and winner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_x      <= X_CTR;
      ball_y      <= Y_CTR;
      dx          <= DIR_POS;
      dy          <= DIR_POS;
      score_l     <= '0;
      score_r     <= '0;
      winner_l    <= 1'b0;
      left_scored <= 1'b0;
    end else begin
      ball_x      <= ball_x_n;
      ball_y      <= ball_y_n;
      dx          <= dx_n;
      dy          <= dy_n;
      score_l     <= score_l_n;
      score_r     <= score_r_n;
      winner_l    <= winner_l_n;
      left_scored <= left_scored_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n       = state;
    ball_x_n      = ball_x;
    ball_y_n      = ball_y;
    dx_n          = dx;
    dy_n          = dy;
    score_l_n     = score_l;
    score_r_n     = score_r;
    winner_l_n    = winner_l;
    left_scored_n = left_scored;
    dir_x         = dx;
    dir_y         = dy;

    case (state)
      IDLE: begin
        ball_x_n = X_CTR;
        ball_y_n = Y_CTR;
        if (bus.startBtn) state_n = SERVE;
      end

      SERVE: begin
        ball_x_n = X_CTR;
        ball_y_n = Y_CTR;
        if (serve_done) state_n = PLAY;
      end

      PLAY: begin
        if (bus.frameTick) begin
          // Simultaneous hits cancel out and leave dx alone.
          if (bus.hitLeftPaddle && !bus.hitRightPaddle) begin
            dir_x = DIR_POS;
          end else if (bus.hitRightPaddle && !bus.hitLeftPaddle) begin
            dir_x = DIR_NEG;
          end

          if ((ball_x == '0) && (dx == DIR_NEG) && !bus.hitLeftPaddle) begin
            state_n       = POINT;
            left_scored_n = 1'b0;
          end else if ((ball_x == X_MAX) && (dx == DIR_POS) && !bus.hitRightPaddle) begin
            state_n       = POINT;
            left_scored_n = 1'b1;
          end else begin
            if (((ball_y <= Y_LO) && (dy == DIR_NEG)) ||
                ((ball_y >= Y_HI) && (dy == DIR_POS))) begin
              dir_y = ~dy;
            end
            dx_n = dir_x;
            dy_n = dir_y;
            // An edge with both paddles asserted keeps dx pointing out;
            // hold x there rather than leave the field.
            if (dir_x == DIR_POS) begin
              if (ball_x != X_MAX) ball_x_n = ball_x + STEP;
            end else begin
              if (ball_x != '0) ball_x_n = ball_x - STEP;
            end
            ball_y_n = (dir_y == DIR_POS) ? (ball_y + STEP) : (ball_y - STEP);
          end
        end
      end

      POINT: begin
        ball_x_n = X_CTR;
        ball_y_n = Y_CTR;
        if (left_scored) begin
          if (score_l != S_WIN) score_l_n = score_l + S_ONE;
          if (score_l_n == S_WIN) begin
            state_n    = GAME_OVER;
            winner_l_n = 1'b1;
          end else begin
            state_n = SERVE;
            dx_n    = DIR_POS;
          end
        end else begin
          if (score_r != S_WIN) score_r_n = score_r + S_ONE;
          if (score_r_n == S_WIN) begin
            state_n    = GAME_OVER;
            winner_l_n = 1'b0;
          end else begin
            state_n = SERVE;
            dx_n    = DIR_NEG;
          end
        end
      end

      GAME_OVER: begin
        ball_x_n = X_CTR;
        ball_y_n = Y_CTR;
        if (bus.startBtn) begin
          score_l_n = '0;
          score_r_n = '0;
          dx_n      = DIR_POS;
          dy_n      = DIR_POS;
          state_n   = SERVE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.ballX      = ball_x;
  assign bus.ballY      = ball_y;
  assign bus.scoreLeft  = score_l;
  assign bus.scoreRight = score_r;
  assign bus.gameState  = state;
  assign bus.winnerLeft = winner_l;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for the pong game sequencer.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pong_game_ctrl_if #(.BIT_WIDTH(10), .SCORE_WIDTH(4)) bus ();

  pong_game_ctrl #(
    .BIT_WIDTH(10), .FIELD_W(640), .FIELD_H(480), .BALL_RADIUS(4),
    .SERVE_DELAY(60), .WIN_SCORE(7), .SCORE_WIDTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, "_x"}, int'(bus.ballX), x);
    check({tag, "_y"}, int'(bus.ballY), y);
  endtask

  task automatic check_state(input string tag, input game_state_t st);
    check({tag, "_state"}, int'(bus.gameState), int'(st));
  endtask

  // One frame tick with the given paddle hits, outputs settled on return.
  task automatic tick(input logic hl, input logic hr);
    @(negedge clk);
    bus.frameTick      = 1'b1;
    bus.hitLeftPaddle  = hl;
    bus.hitRightPaddle = hr;
    @(negedge clk);
    bus.frameTick      = 1'b0;
    bus.hitLeftPaddle  = 1'b0;
    bus.hitRightPaddle = 1'b0;
  endtask

  task automatic press_start();
    @(negedge clk);
    bus.startBtn = 1'b1;
    @(negedge clk);
    bus.startBtn = 1'b0;
  endtask

  task automatic serve(input string tag);
    repeat (60) tick(1'b0, 1'b0);
    check_state(tag, PLAY);
    check_ball(tag, 320, 240);
  endtask

  // Plain ticks until the rally ends, bounded.
  task automatic run_to_point(input string tag, input int exp_ticks);
    int n = 0;
    while (bus.gameState == PLAY && n < 2000) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check({tag, "_ticks"}, n, exp_ticks);
    check_state(tag, POINT);
  endtask

  initial begin
    bus.frameTick      = 1'b0;
    bus.startBtn       = 1'b0;
    bus.hitLeftPaddle  = 1'b0;
    bus.hitRightPaddle = 1'b0;

    // reset values
    #12;
    check_state("rst", IDLE);
    check_ball("rst", 320, 240);
    check("rst_sl", int'(bus.scoreLeft), 0);
    check("rst_sr", int'(bus.scoreRight), 0);
    check("rst_win", int'(bus.winnerLeft), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // start, serve delay (hits ignored in SERVE), first move
    press_start();
    check_state("start", SERVE);
    repeat (59) tick(1'b0, 1'b1);
    check_state("serve59", SERVE);
    tick(1'b0, 1'b0);
    check_state("serve60", PLAY);
    check_ball("serve60", 320, 240);
    tick(1'b0, 1'b0);
    check_ball("move1", 321, 241);

    // walk to the bottom wall limit, x oscillating with paddle hits
    repeat (10) tick(1'b0, 1'b0);
    check_ball("walk", 331, 251);
    for (int k = 0; k < 224; k++) begin
      if (k % 2 == 0) tick(1'b0, 1'b1);
      else            tick(1'b1, 1'b0);
    end
    check_ball("at_limit", 331, 475);
    tick(1'b0, 1'b0);
    check_ball("wall_flip", 332, 474);
    tick(1'b0, 1'b0);
    check_ball("after_flip", 333, 473);

    // left paddle hit at x=20
    tick(1'b0, 1'b1);
    repeat (312) tick(1'b0, 1'b0);
    check_ball("x20", 20, 160);
    tick(1'b1, 1'b0);
    check_ball("hit_left", 21, 159);
    check("hit_left_sl", int'(bus.scoreLeft), 0);
    check("hit_left_sr", int'(bus.scoreRight), 0);

    // left miss, right scores, serve back toward left
    tick(1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0);
    check_ball("x0", 0, 138);
    tick(1'b0, 1'b0);
    check_state("miss_l", POINT);
    check_ball("miss_l", 0, 138);
    @(negedge clk);
    check_state("pt_r", SERVE);
    check("pt_r_sr", int'(bus.scoreRight), 1);
    check("pt_r_sl", int'(bus.scoreLeft), 0);
    check_ball("pt_r", 320, 240);
    serve("serve_r");
    tick(1'b0, 1'b0);
    check_ball("serve_dx_neg", 319, 239);

    // left scores up to 6
    tick(1'b1, 1'b0);
    check_ball("turn_right", 320, 238);
    run_to_point("rally_l1", 320);
    @(negedge clk);
    check("rally_l1_sl", int'(bus.scoreLeft), 1);
    for (int r = 2; r <= 6; r++) begin
      serve("serve_l");
      run_to_point("rally_l", 320);
      @(negedge clk);
      check_state("rally_l", SERVE);
      check("rally_l_sl", int'(bus.scoreLeft), r);
    end

    // seventh point wins the game for left
    serve("serve_l7");
    run_to_point("rally_l7", 320);
    @(negedge clk);
    check_state("win", GAME_OVER);
    check("win_sl", int'(bus.scoreLeft), 7);
    check("win_sr", int'(bus.scoreRight), 1);
    check("win_left", int'(bus.winnerLeft), 1);
    check_ball("win", 320, 240);
    tick(1'b1, 1'b1);
    check_state("go_tick", GAME_OVER);
    check("go_tick_sl", int'(bus.scoreLeft), 7);

    // restart clears scores and directions
    press_start();
    check_state("restart", SERVE);
    check("restart_sl", int'(bus.scoreLeft), 0);
    check("restart_sr", int'(bus.scoreRight), 0);
    serve("serve_new");
    tick(1'b0, 1'b0);
    check_ball("new_dir", 321, 241);

    // right scores, then async reset mid-rally
    tick(1'b0, 1'b1);
    check_ball("turn_left", 320, 242);
    run_to_point("rally_r", 321);
    @(negedge clk);
    check("rally_r_sr", int'(bus.scoreRight), 1);
    serve("serve_r2");
    tick(1'b0, 1'b0);
    check("serve_r2_x", int'(bus.ballX), 319);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", IDLE);
    check_ball("async_rst", 320, 240);
    check("async_rst_sr", int'(bus.scoreRight), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // both paddles asserted leaves dx unchanged
    press_start();
    serve("serve_both");
    tick(1'b0, 1'b1);
    check_ball("dx_neg", 319, 241);
    tick(1'b1, 1'b1);
    check_ball("both_hits", 318, 242);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
